// File: rtl/nw_index_sequencer_if.sv
// nw_index_sequencer_if: control/index bundle between the NW control FSM and the cell-index sequencer
interface nw_index_sequencer_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int IW = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int JW = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
);
  logic          start;
  logic [1:0]    mode;
  logic          advance;
  logic          abort;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [AW-1:0] addr;
  logic          valid;
  logic          first;
  logic          last;
  logic          done;
  logic          busy;
  modport master(output start, mode, advance, abort, input i, j, addr, valid, first, last, done, busy);
  modport slave(input start, mode, advance, abort, output i, j, addr, valid, first, last, done, busy);
endinterface

// File: rtl/nw_index_sequencer.sv
// nw_index_sequencer: (i,j) cell walker for Needleman-Wunsch matrix fill, row/column/anti-diagonal order
module nw_index_sequencer #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int IW = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int JW = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input logic clk,
  input logic rst,
  nw_index_sequencer_if.slave bus
);
  localparam int DW = ((IW > JW) ? IW : JW) + 1;
  localparam logic [IW-1:0] IMAX = IW'(ROWS - 1);
  localparam logic [JW-1:0] JMAX = JW'(COLS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [1:0] mode_r;
  logic [DW-1:0] d1, di;
  logic [IW-1:0] ni;
  logic [JW-1:0] nj;
  logic [AW-1:0] na;
  logic wrap;
  // wavefront jumps to the next diagonal from its top-right end, entering at the lowest legal row
  always_comb begin
    d1 = DW'(bus.i) + DW'(bus.j) + DW'(1);
    di = (d1 > DW'(ROWS - 1)) ? DW'(ROWS - 1) : d1;
    wrap = (bus.i == '0) || (bus.j == JMAX);
    ni = (mode_r == 2'b10) ? (wrap ? IW'(di) : bus.i - IW'(1))
       : (mode_r == 2'b01) ? ((bus.i == IMAX) ? '0 : bus.i + IW'(1))
       : ((bus.j == JMAX) ? bus.i + IW'(1) : bus.i);
    nj = (mode_r == 2'b10) ? (wrap ? JW'(d1 - di) : bus.j + JW'(1))
       : (mode_r == 2'b01) ? ((bus.i == IMAX) ? bus.j + JW'(1) : bus.j)
       : ((bus.j == JMAX) ? '0 : bus.j + JW'(1));
    na = AW'(ni) * AW'(COLS) + AW'(nj);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mode_r <= '0;
      bus.i <= '0;
      bus.j <= '0;
      bus.addr <= '0;
      bus.valid <= 1'b0;
      bus.first <= 1'b0;
      bus.last <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else if (bus.abort) begin
      state <= IDLE;
      bus.i <= '0;
      bus.j <= '0;
      bus.addr <= '0;
      bus.valid <= 1'b0;
      bus.first <= 1'b0;
      bus.last <= 1'b0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else if (state == IDLE) begin
      bus.done <= 1'b0;
      if (bus.start) begin
        state <= RUN;
        mode_r <= bus.mode;
        bus.i <= '0;
        bus.j <= '0;
        bus.addr <= '0;
        bus.valid <= 1'b1;
        bus.first <= 1'b1;
        bus.last <= 1'b0;
        bus.busy <= 1'b1;
      end
    end else if (state == RUN) begin
      if (bus.advance && bus.last) begin
        state <= DONE;
        bus.valid <= 1'b0;
        bus.first <= 1'b0;
        bus.last <= 1'b0;
        bus.done <= 1'b1;
      end else if (bus.advance) begin
        bus.i <= ni;
        bus.j <= nj;
        bus.addr <= na;
        bus.first <= 1'b0;
        bus.last <= (ni == IMAX) && (nj == JMAX);
      end
    end else begin
      state <= IDLE;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end
endmodule

// File: tb/tb_nw_index_sequencer.sv
// tb_nw_index_sequencer: four sequencer shapes in lockstep against a visit-list reference model
module tb_nw_index_sequencer;
  localparam int NK = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, advance = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'b00;
  always #5 clk = ~clk;
  int rs[NK] = '{2, 3, 2, 3};
  int cs[NK] = '{3, 3, 4, 2};
  int npass = 0, ntotal = 0;
  int mst[NK], mm[NK], mp[NK], ei[NK], ej[NK];
  int ordi[NK][3][9], ordj[NK][3][9];
  logic [31:0] o[NK];
  typedef struct {int ti; int tj; int ta; bit v; bit f; bit l; bit d; bit b;} vec_t;
  vec_t tbl[11];

  nw_index_sequencer_if #(.ROWS(2), .COLS(3)) b0();
  nw_index_sequencer_if #(.ROWS(3), .COLS(3)) b1();
  nw_index_sequencer_if #(.ROWS(2), .COLS(4)) b2();
  nw_index_sequencer_if #(.ROWS(3), .COLS(2)) b3();
  nw_index_sequencer #(.ROWS(2), .COLS(3)) u0(.clk(clk), .rst(rst), .bus(b0.slave));
  nw_index_sequencer #(.ROWS(3), .COLS(3)) u1(.clk(clk), .rst(rst), .bus(b1.slave));
  nw_index_sequencer #(.ROWS(2), .COLS(4)) u2(.clk(clk), .rst(rst), .bus(b2.slave));
  nw_index_sequencer #(.ROWS(3), .COLS(2)) u3(.clk(clk), .rst(rst), .bus(b3.slave));
  assign b0.start = start; assign b0.mode = mode; assign b0.advance = advance; assign b0.abort = abort;
  assign b1.start = start; assign b1.mode = mode; assign b1.advance = advance; assign b1.abort = abort;
  assign b2.start = start; assign b2.mode = mode; assign b2.advance = advance; assign b2.abort = abort;
  assign b3.start = start; assign b3.mode = mode; assign b3.advance = advance; assign b3.abort = abort;
  assign o[0] = {8'(b0.i), 8'(b0.j), 8'(b0.addr), 3'b0, b0.valid, b0.first, b0.last, b0.done, b0.busy};
  assign o[1] = {8'(b1.i), 8'(b1.j), 8'(b1.addr), 3'b0, b1.valid, b1.first, b1.last, b1.done, b1.busy};
  assign o[2] = {8'(b2.i), 8'(b2.j), 8'(b2.addr), 3'b0, b2.valid, b2.first, b2.last, b2.done, b2.busy};
  assign o[3] = {8'(b3.i), 8'(b3.j), 8'(b3.addr), 3'b0, b3.valid, b3.first, b3.last, b3.done, b3.busy};

  function automatic logic [31:0] expv(int k);
    bit v = (mst[k] == 1);
    return {8'(ei[k]), 8'(ej[k]), 8'(ei[k] * cs[k] + ej[k]), 3'b0, v,
            v && ei[k] == 0 && ej[k] == 0, v && ei[k] == rs[k] - 1 && ej[k] == cs[k] - 1,
            mst[k] == 2, mst[k] != 0};
  endfunction

  function automatic logic [31:0] pack(vec_t t);
    return {8'(t.ti), 8'(t.tj), 8'(t.ta), 3'b0, t.v, t.f, t.l, t.d, t.b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (i,j,addr,flags v/f/l/d/b)", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      mst[k] = 0; mm[k] = 0; mp[k] = 0; ei[k] = 0; ej[k] = 0;
    end
  endtask

  task automatic mstep(input bit s, input logic [1:0] md, input bit a, input bit ab);
    for (int k = 0; k < NK; k++) begin
      if (ab) begin
        mst[k] = 0; ei[k] = 0; ej[k] = 0;
      end else if (mst[k] == 0) begin
        if (s) begin
          mst[k] = 1; mm[k] = (md == 2'b11) ? 0 : int'(md); mp[k] = 0;
          ei[k] = ordi[k][mm[k]][0]; ej[k] = ordj[k][mm[k]][0];
        end
      end else if (mst[k] == 1) begin
        if (a && mp[k] == rs[k] * cs[k] - 1) mst[k] = 2;
        else if (a) begin
          mp[k]++;
          ei[k] = ordi[k][mm[k]][mp[k]]; ej[k] = ordj[k][mm[k]][mp[k]];
        end
      end else mst[k] = 0;
    end
  endtask

  task automatic cyc(input bit s, input logic [1:0] md, input bit a, input bit ab);
    start = s; mode = md; advance = a; abort = ab;
    @(posedge clk);
    mstep(s, md, a, ab);
    @(negedge clk);
    for (int k = 0; k < NK; k++) chk($sformatf("model k%0d", k), o[k], expv(k));
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      int n;
      n = 0;
      for (int a = 0; a < rs[k]; a++) for (int b = 0; b < cs[k]; b++) begin
        ordi[k][0][n] = a; ordj[k][0][n] = b; n++;
      end
      n = 0;
      for (int b = 0; b < cs[k]; b++) for (int a = 0; a < rs[k]; a++) begin
        ordi[k][1][n] = a; ordj[k][1][n] = b; n++;
      end
      n = 0;
      for (int d = 0; d <= rs[k] + cs[k] - 2; d++)
        for (int a = (d < rs[k] - 1) ? d : rs[k] - 1; a >= 0; a--)
          if (d - a < cs[k]) begin
            ordi[k][2][n] = a; ordj[k][2][n] = d - a; n++;
          end
    end
    tbl = '{'{0, 0, 0, 1, 1, 0, 0, 1}, '{1, 0, 3, 1, 0, 0, 0, 1}, '{0, 1, 1, 1, 0, 0, 0, 1},
            '{2, 0, 6, 1, 0, 0, 0, 1}, '{1, 1, 4, 1, 0, 0, 0, 1}, '{0, 2, 2, 1, 0, 0, 0, 1},
            '{2, 1, 7, 1, 0, 0, 0, 1}, '{1, 2, 5, 1, 0, 0, 0, 1}, '{2, 2, 8, 1, 0, 1, 0, 1},
            '{2, 2, 8, 0, 0, 0, 1, 1}, '{2, 2, 8, 0, 0, 0, 0, 0}};
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < NK; k++) chk($sformatf("reset k%0d", k), o[k], 32'h0);
    rst = 1'b0;
    cyc(1, 2'b10, 0, 0);
    for (int t = 0; t < 11; t++) begin
      chk($sformatf("diag3x3 step%0d", t), o[1], pack(tbl[t]));
      cyc(0, 2'b10, 1, 0);
    end
    cyc(1, 2'b00, 1, 0);
    for (int t = 0; t < 3; t++) cyc(0, 2'b00, 1, 0);
    cyc(0, 2'b00, 1, 1);
    chk("abort to idle", o[0], 32'h0);
    cyc(0, 2'b00, 0, 0);
    chk("abort no done", o[0], 32'h0);
    cyc(1, 2'b00, 0, 0);
    chk("restart at origin", o[0], 32'h0000_0019);
    cyc(0, 2'b00, 1, 0);
    cyc(1, 2'b01, 1, 0);
    chk("start ignored busy", o[0], 32'h0002_0211);
    cyc(0, 2'b00, 1, 0);
    cyc(0, 2'b00, 1, 0);
    chk("at cell 1,1", o[0], 32'h0101_0411);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NK; k++) chk($sformatf("async reset k%0d", k), o[k], 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 2'b00, 1, 0);
    for (int t = 0; t < 12; t++) cyc(0, 2'b00, 1, 0);
    cyc(1, 2'b01, 0, 0);
    for (int t = 0; t < 40; t++) cyc(0, 2'b01, (t % 4 == 0) || (t % 4 == 3), 0);
    for (int t = 0; t < 600; t++)
      cyc($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/nw_index_sequencer.md
Name: nw_index_sequencer

Overview:
- Parametrised (i,j) cell-index generator that drives Needleman-Wunsch matrix RAM fill and scoring passes.
- Supports independent row and column counts, three traversal orders and a valid/advance handshake.
- Also provides a linear RAM address, first/last flags and a one-cycle done pulse.
- Sits between the control FSM and the RAM address/write-enable logic.

Parameters:
ROWS, 4, number of matrix rows (>=2)
COLS, 4, number of matrix columns (>=2)
IW, $clog2(ROWS), width of i (minimum 1)
JW, $clog2(COLS), width of j (minimum 1)
AW, $clog2(ROWS*COLS), width of linear address (minimum 1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a traversal; sampled only in IDLE
mode  in  2  traversal order, latched on accepted start: 00 row-major, 01 column-major, 10 anti-diagonal, 11 reserved (treated as row-major)
advance  in  1  consumer accepts current index; step occurs when advance && valid
abort  in  1  synchronous return to IDLE
i  out  IW  current row index
j  out  JW  current column index
addr  out  AW  i*COLS + j, consistent with i/j in the same cycle
valid  out  1  i/j/addr are a live cell
first  out  1  valid && i==0 && j==0
last  out  1  valid && i==ROWS-1 && j==COLS-1
done  out  1  one-cycle pulse after the last cell is accepted
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; i=0, j=0, mode register=00; valid=first=last=done=busy=0; addr=0.
- States:
  - IDLE: valid=0, i/j hold their last values. start=1 -> RUN, i=0, j=0, mode latched. valid=1 on the next cycle (1-cycle start latency).
  - RUN: valid=1. advance=1 && !last -> step per mode. advance=1 && last -> DONE.
  - DONE: exactly one cycle. done=1, valid=0 -> IDLE.
- Traversal steps:
  - Row-major: j==COLS-1 ? (j=0, i=i+1) : j=j+1.
  - Column-major: i==ROWS-1 ? (i=0, j=j+1) : i=i+1.
  - Anti-diagonal (wavefront, d=i+j): if i==0 or j==COLS-1, move to diagonal d+1 with i=min(d+1, ROWS-1), j=d+1-i. Otherwise i=i-1, j=j+1.
  - Every mode visits each of ROWS*COLS cells exactly once, starting at (0,0) and ending at (ROWS-1, COLS-1).
- advance=0 in RUN: all outputs hold (stall of unbounded length).
- start is ignored in RUN and DONE; mode changes mid-run are ignored.
- abort has priority over advance and start in every state. Result: IDLE next cycle, valid=0, no done pulse, i/j reset to 0.
- start asserted in the same cycle as the DONE->IDLE transition is not accepted; it must be asserted again in IDLE.
- Async rst mid-traversal: immediate return to reset values, no done pulse.
- Arithmetic: d+1 is computed at max(IW,JW)+1 bits to avoid overflow. addr is computed at AW bits with no truncation for legal indices.

Test Plan:
- ROWS=2, COLS=3, mode 00, advance held high: (i,j)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2); addr=0..5; last on (1,2); done pulse on the cycle after; busy falls with done.
- ROWS=3, COLS=3, mode 10: sequence (0,0),(1,0),(0,1),(2,0),(1,1),(0,2),(2,1),(1,2),(2,2); first only on (0,0); addr of (2,1)=7.
- ROWS=2, COLS=4, mode 10 (non-square): (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(0,3),(1,3); 8 cells, no duplicates.
- ROWS=3, COLS=2, mode 01 with advance toggled 1,0,0,1: indices hold during stalls; order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
- Start mode 00; after 3 steps assert abort together with advance: IDLE next cycle, valid=0, i=j=0, done never asserted. A new start then resumes from (0,0).
- Assert start while busy: ignored. Assert rst at cell (1,1): outputs return to zero immediately; a later start and full run complete normally.
